// File: rtl/gate_pair_pkg.sv
// gate_pair_pkg
// Shared definitions for the gate-pair sweeper: FSM state encoding, the
// number of truth-table vectors, and the golden gate-pair functions.
package gate_pair_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int NUM_VEC = 4;

   function automatic logic exp_a(input logic x, input logic y);
      return ~x & y;
   endfunction

   function automatic logic exp_b(input logic x, input logic y);
      return ~(x ^ y);
   endfunction

endpackage

// File: rtl/gate_pair_ref.sv
// gate_pair_ref
// Purely combinational golden model of the gate pair.
// Ports:
//   drv_x, drv_y : stimulus presented to the gate pair
//   exp_a        : expected a = ~x & y
//   exp_b        : expected b = ~(x ^ y)
module gate_pair_ref
   import gate_pair_pkg::*;
(
   input  logic drv_x,
   input  logic drv_y,
   output logic exp_a,
   output logic exp_b
);

   assign exp_a = gate_pair_pkg::exp_a(drv_x, drv_y);
   assign exp_b = gate_pair_pkg::exp_b(drv_x, drv_y);

endmodule

// File: rtl/gate_pair_sweeper.sv
// gate_pair_sweeper
// Clocked, restartable self-checking sequencer around the two-input gate
// pair. Drives x/y through 00,01,10,11 for N_PASSES sweeps, holds each
// vector SETTLE_CYCLES cycles, checks a/b against the golden model, and
// reports sticky per-vector fail flags plus a saturating mismatch count.
// Ports:
//   clk, rst_n   : clock (rising edge), async active-low reset
//   start        : sweep request, sampled only in IDLE
//   drv_x, drv_y : stimulus to the gate pair
//   dut_a, dut_b : gate-pair outputs under check
//   busy         : sweep in progress (SETTLE/CHECK)
//   done         : one-cycle pulse at sweep end
//   err_count    : saturating count of mismatching samples
//   err_vec      : sticky flags, bit 2*i = a failed on vector i, 2*i+1 = b
//   pass         : last sweep had no mismatches; held until next start
//
// state  | meaning
// IDLE   | waiting for start, results held
// SETTLE | vector idx driven, settle_cnt counting down to 0
// CHECK  | one cycle: compare and record, advance vector/pass
// DONE   | one-cycle done pulse, pass registered on entry
module gate_pair_sweeper
   import gate_pair_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int N_PASSES      = 1,
   parameter int CNT_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             drv_x,
   output logic             drv_y,
   input  logic             dut_a,
   input  logic             dut_b,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [7:0]       err_vec,
   output logic             pass
);

   localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [7:0]       LAST_PASS   = 8'(N_PASSES - 1);
   localparam logic [1:0]       LAST_VEC    = 2'(NUM_VEC - 1);
   localparam logic [CNT_W+1:0] ERR_MAX     = {2'b00, {CNT_W{1'b1}}};

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       idx;
   logic [7:0]       pass_cnt;
   logic [3:0]       settle_cnt;

   logic             ref_a;
   logic             ref_b;
   logic             fail_a;
   logic             fail_b;
   logic [7:0]       fail_bits;
   logic [CNT_W+1:0] err_sum;
   logic [CNT_W-1:0] err_count_nxt;
   logic             last_vec;
   logic             last_pass;

   gate_pair_ref u_ref (
      .drv_x (drv_x),
      .drv_y (drv_y),
      .exp_a (ref_a),
      .exp_b (ref_b)
   );

   assign last_vec  = (idx == LAST_VEC);
   assign last_pass = (pass_cnt == LAST_PASS);

   assign fail_a = (dut_a != ref_a);
   assign fail_b = (dut_b != ref_b);

   always_comb begin
      fail_bits = '0;
      fail_bits[{idx, 1'b0}] = fail_a;
      fail_bits[{idx, 1'b1}] = fail_b;
   end

   // Two extra bits of headroom so a double mismatch near the top cannot wrap.
   assign err_sum = {2'b00, err_count} + (CNT_W+2)'(fail_a) + (CNT_W+2)'(fail_b);
   assign err_count_nxt = (err_sum > ERR_MAX) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_SETTLE;
         ST_SETTLE: if (settle_cnt == 4'd0) state_nxt = ST_CHECK;
         ST_CHECK:  state_nxt = (last_vec && last_pass) ? ST_DONE : ST_SETTLE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy  = 1'b0;
      done  = 1'b0;
      drv_x = 1'b0;
      drv_y = 1'b0;
      case (state)
         ST_SETTLE, ST_CHECK: begin
            busy  = 1'b1;
            drv_x = idx[1];
            drv_y = idx[0];
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Sequencer counters and scoreboard
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         pass_cnt   <= '0;
         settle_cnt <= '0;
         err_count  <= '0;
         err_vec    <= '0;
         pass       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  idx        <= '0;
                  pass_cnt   <= '0;
                  settle_cnt <= SETTLE_LOAD;
                  err_count  <= '0;
                  err_vec    <= '0;
                  pass       <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
            end
            ST_CHECK: begin
               err_count  <= err_count_nxt;
               err_vec    <= err_vec | fail_bits;
               settle_cnt <= SETTLE_LOAD;
               if (!last_vec) begin
                  idx <= idx + 2'd1;
               end else if (!last_pass) begin
                  idx      <= '0;
                  pass_cnt <= pass_cnt + 8'd1;
               end else begin
                  // Uses the count including this final check's mismatches.
                  pass <= (err_count_nxt == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_pair_sweeper.sv
// tb_gate_pair_sweeper
// Directed bench for gate_pair_sweeper. Three instances cover the default
// configuration, a multi-pass saturating configuration, and a one-cycle
// settle configuration. Each instance sees a bench-side gate-pair model with
// selectable faults (0 = correct, 1 = tied low, 2 = inverted).
module tb_gate_pair_sweeper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start0, start1, start2;
   int   mode_a0, mode_b0, mode_a1, mode_b1, mode_a2, mode_b2;

   int n_cmp  = 0;
   int n_fail = 0;
   int edges;

   function automatic logic gate(input int mode, input logic good);
      case (mode)
         0:       return good;
         1:       return 1'b0;
         default: return ~good;
      endcase
   endfunction

   logic       d0_x, d0_y, d0_a, d0_b, d0_busy, d0_done, d0_pass;
   logic [3:0] d0_cnt;
   logic [7:0] d0_vec;
   logic       d1_x, d1_y, d1_a, d1_b, d1_busy, d1_done, d1_pass;
   logic [2:0] d1_cnt;
   logic [7:0] d1_vec;
   logic       d2_x, d2_y, d2_a, d2_b, d2_busy, d2_done, d2_pass;
   logic [3:0] d2_cnt;
   logic [7:0] d2_vec;

   assign d0_a = gate(mode_a0, ~d0_x & d0_y);
   assign d0_b = gate(mode_b0, ~(d0_x ^ d0_y));
   assign d1_a = gate(mode_a1, ~d1_x & d1_y);
   assign d1_b = gate(mode_b1, ~(d1_x ^ d1_y));
   assign d2_a = gate(mode_a2, ~d2_x & d2_y);
   assign d2_b = gate(mode_b2, ~(d2_x ^ d2_y));

   gate_pair_sweeper #(.SETTLE_CYCLES(2), .N_PASSES(1), .CNT_W(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .drv_x(d0_x), .drv_y(d0_y),
      .dut_a(d0_a), .dut_b(d0_b), .busy(d0_busy), .done(d0_done),
      .err_count(d0_cnt), .err_vec(d0_vec), .pass(d0_pass)
   );

   gate_pair_sweeper #(.SETTLE_CYCLES(2), .N_PASSES(4), .CNT_W(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .drv_x(d1_x), .drv_y(d1_y),
      .dut_a(d1_a), .dut_b(d1_b), .busy(d1_busy), .done(d1_done),
      .err_count(d1_cnt), .err_vec(d1_vec), .pass(d1_pass)
   );

   gate_pair_sweeper #(.SETTLE_CYCLES(1), .N_PASSES(1), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .drv_x(d2_x), .drv_y(d2_y),
      .dut_a(d2_a), .dut_b(d2_b), .busy(d2_busy), .done(d2_done),
      .err_count(d2_cnt), .err_vec(d2_vec), .pass(d2_pass)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic done_of(input int sel);
      case (sel)
         0:       return d0_done;
         1:       return d1_done;
         default: return d2_done;
      endcase
   endfunction

   // Counts edges from the current cycle until done is seen, bounded.
   task automatic wait_done(input int sel, output int n);
      n = 0;
      while (done_of(sel) !== 1'b1 && n < 500) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b0;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      mode_a0 = 0; mode_b0 = 0; mode_a1 = 0; mode_b1 = 0; mode_a2 = 0; mode_b2 = 0;
      tick(); tick();

      // Reset state
      check("rst_drv",  {d0_x, d0_y}, 0);
      check("rst_busy", d0_busy, 0);
      check("rst_done", d0_done, 0);
      check("rst_cnt",  d0_cnt, 0);
      check("rst_vec",  d0_vec, 0);
      check("rst_pass", d0_pass, 0);
      check("rst_busy1", d1_busy, 0);
      check("rst_busy2", d2_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 1: correct gate pair, default timing
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int c = 0; c < 12; c++) begin
         check("t1_drv",  {d0_x, d0_y}, 32'(c / 3));
         check("t1_busy", d0_busy, 1);
         check("t1_done", d0_done, 0);
         tick();
      end
      check("t1_done_pulse", d0_done, 1);
      check("t1_busy_done",  d0_busy, 0);
      check("t1_drv_done",   {d0_x, d0_y}, 0);
      check("t1_cnt",  d0_cnt, 0);
      check("t1_vec",  d0_vec, 8'h00);
      check("t1_pass", d0_pass, 1);
      tick();
      check("t1_done_off", d0_done, 0);
      check("t1_pass_held", d0_pass, 1);

      // 2: a tied low
      mode_a0 = 1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done(0, edges);
      check("t2_edges", edges, 12);
      check("t2_cnt",  d0_cnt, 1);
      check("t2_vec",  d0_vec, 8'h04);
      check("t2_pass", d0_pass, 0);
      tick(); tick();
      check("t2_cnt_held", d0_cnt, 1);
      check("t2_vec_held", d0_vec, 8'h04);

      // 3: b inverted
      mode_a0 = 0;
      mode_b0 = 2;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      check("t3_cleared", d0_vec, 8'h00);
      wait_done(0, edges);
      check("t3_edges", edges, 12);
      check("t3_cnt",  d0_cnt, 4);
      check("t3_vec",  d0_vec, 8'hAA);
      check("t3_pass", d0_pass, 0);
      tick();
      mode_b0 = 0;

      // 4: four passes, both inverted, 3-bit saturating count
      mode_a1 = 2;
      mode_b1 = 2;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      wait_done(1, edges);
      check("t4_edges", edges, 48);
      check("t4_cnt",  d1_cnt, 7);
      check("t4_vec",  d1_vec, 8'hFF);
      check("t4_pass", d1_pass, 0);
      tick();

      // 5: start ignored while busy, reset mid-sweep
      mode_a0 = 1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      tick(); tick(); tick(); tick();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      check("t5_ignore_drv",  {d0_x, d0_y}, 1);
      check("t5_ignore_busy", d0_busy, 1);
      tick();
      check("t5_idx2_drv", {d0_x, d0_y}, 2);
      check("t5_mid_cnt",  d0_cnt, 1);
      check("t5_mid_vec",  d0_vec, 8'h04);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_drv",  {d0_x, d0_y}, 0);
      check("t5_rst_busy", d0_busy, 0);
      check("t5_rst_done", d0_done, 0);
      check("t5_rst_cnt",  d0_cnt, 0);
      check("t5_rst_vec",  d0_vec, 0);
      check("t5_rst_pass", d0_pass, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t5_no_done", d0_done, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mode_a0 = 0;
      tick();
      check("t5_idle_busy", d0_busy, 0);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      check("t5_restart_drv", {d0_x, d0_y}, 0);
      check("t5_restart_cnt", d0_cnt, 0);
      wait_done(0, edges);
      check("t5_edges", edges, 12);
      check("t5_cnt",  d0_cnt, 0);
      check("t5_pass", d0_pass, 1);
      tick();

      // 6: one-cycle settle, start held through DONE
      start2 = 1'b1;
      tick();
      for (int c = 0; c < 8; c++) begin
         check("t6_drv",  {d2_x, d2_y}, 32'(c / 2));
         check("t6_busy", d2_busy, 1);
         tick();
      end
      check("t6_done", d2_done, 1);
      tick();
      check("t6_idle_busy", d2_busy, 0);
      check("t6_idle_done", d2_done, 0);
      check("t6_pass", d2_pass, 1);
      tick();
      check("t6_reaccept_busy", d2_busy, 1);
      check("t6_reaccept_drv",  {d2_x, d2_y}, 0);
      start2 = 1'b0;
      wait_done(2, edges);
      check("t6_edges", edges, 8);
      check("t6_cnt",  d2_cnt, 0);
      check("t6_pass2", d2_pass, 1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
